seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Parametrised, bus-mapped multiplexed seven-segment display controller, the successor to the fixed 8-digit decimal scanner on the CPU's peripheral bus. It holds a 32-bit display value plus control, decimal-point and blanking registers, then time-multiplexes up to 8 digits. Digits are decoded in hex (0–F) or decimal mode, with optional leading-zero suppression, inter-digit ghosting gaps and configurable output polarity. Register writes come from the CPU bus, and the pins drive the board's digit selects and segment lines.

## Interface
- DIGITS, 8: number of digits scanned, 1..8; digit i shows DATA[4i+3:4i].
- SCAN_DIV, 100000: sck cycles each digit is lit (>=1).
- GAP_CYCLES, 2: sck cycles all outputs are inactive between digits (>=0).
- SEL_ACTIVE_LOW, 0: 1 means seg_sel is active-low.
- SEG_ACTIVE_LOW, 0: 1 means seg_code is active-low.
- sck  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- cs_n  in  1  bus chip select, active-low.
- rw  in  1  1 = write, 0 = read.
- addr  in  2  register select.
- mosi  in  32  write data.
- miso  out  32  read data (combinational).
- seg_sel  out  DIGITS  one-hot digit select (registered).
- seg_code  out  8  segment code: bit7 = dp, bits6:0 = g..a (registered).

## Operation
- Register map (unused bits read 0, writes to them ignored):
  - 0 DATA: 32-bit, reset 0.
  - 1 CTRL: bit0 EN (reset 1), bit1 HEX (reset 1), bit2 LZS (reset 0).
  - 2 DP: DIGITS bits, reset 0.
  - 3 BLANK: DIGITS bits, reset 0.
- Write: on posedge sck when cs_n=0 and rw=1, the addressed register takes mosi (masked).
- Read: miso = addressed register when cs_n=0 and rw=0, else 0.
- Decode, active-high, before polarity:
  - Digits 0–9: 3f 06 5b 4f 66 6d 7d 07 7f 6f.
  - Digits A–F: 77 7c 39 5e 79 71.
  - If HEX=0, nibbles >9 show 40 ("-").
  - DP[i] sets bit7.
- A digit is blanked (code 00, bit7 included) when either:
  - BLANK[i]=1, or
  - LZS=1, i>0 and all nibbles i..DIGITS-1 are 0. Digit 0 is never zero-suppressed.
- Shadow copy: DATA, HEX, LZS, DP and BLANK are copied into a shadow on every GAP→SHOW transition for idx 0. A frame never tears; writes show from the next frame.
- FSM states: IDLE, GAP, SHOW; counter cnt; digit index idx.
  - GAP: outputs inactive. After GAP_CYCLES cycles, go to SHOW and load seg_sel/seg_code for idx. With GAP_CYCLES=0, GAP lasts 0 cycles and SHOW is loaded on the same edge.
  - SHOW: lasts SCAN_DIV cycles. Then outputs go inactive, idx increments (DIGITS-1 wraps to 0), and the FSM enters GAP.
  - EN=0 in any state: on the next edge go to IDLE, outputs inactive, idx=0, cnt=0.
  - IDLE, EN=1: go to GAP with idx=0.
- Inactive outputs: seg_sel = all 0, or all 1 if SEL_ACTIVE_LOW. seg_code = 00, or ff if SEG_ACTIVE_LOW. Polarity is applied by inverting the active-high value.

## Timing
- Reset (async assert, sync release by board): state GAP, idx=0, cnt=0, all registers and shadow at their reset values, seg_sel/seg_code inactive. miso is combinational, so it is 0 unless a read is selected.
- From reset release, first digit lights at edge GAP_CYCLES+1 (when GAP_CYCLES=0, first edge).
- Frame period: DIGITS*(SCAN_DIV+GAP_CYCLES) cycles.
- Register write is visible on miso the cycle after the write edge.
- A write landing on the same edge as the idx-0 shadow capture is not captured; it shows the next frame.
- A CTRL write with EN=0 blanks outputs one edge after the write edge.
- A write and a read cannot coincide (single rw).

## Test plan
- Reset, DIGITS=8, SCAN_DIV=4, GAP_CYCLES=1, DATA=0x12345678 written before frame start -> seg_sel steps 01,02,…,80. Codes 7f,07,7d,6d,66,4f,5b,06, each held 4 cycles with 1-cycle all-inactive gaps. Frame = 40 cycles; wraps to 01.
- HEX=1, DATA=0xFEDCBA98 -> digits show 7f,6f,77,7c,39,5e,79,71. Then CTRL=0x1 (HEX=0) -> next frame digits 2..7 show 40.
- LZS=1, DATA=0x00000000 -> only digit 0 shows 3f, others 00. DATA=0x00010200 -> digits 5..7 blank, digit 1 shows 3f.
- DP=0x05, BLANK=0x02, DATA=0 -> digit0 bf, digit1 00, digit2 bf, others 3f. Readback: addr2=0x05, addr3=0x02, with cs_n=1 miso=0.
- Write DATA mid-frame at idx 3 -> current frame keeps old value, next frame shows new. Write CTRL=0x2 (EN=0) during SHOW -> next edge outputs inactive. Re-enable -> digit 0 lights after GAP_CYCLES+1 edges.
- SEL_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1, DIGITS=4 -> reset gives seg_sel=f, seg_code=ff. Digit 0 of value 1 gives seg_sel=e, seg_code=f9. Assert rst mid-SHOW -> outputs inactive immediately and DATA reads 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Bus-mapped multiplexed seven-segment display controller: register file,
// per-frame shadow copy, and a GAP/SHOW scan FSM driving digit selects and segments.
module seg_scan_ctrl #(
   parameter int DIGITS         = 8,
   parameter int SCAN_DIV       = 100000,
   parameter int GAP_CYCLES     = 2,
   parameter bit SEL_ACTIVE_LOW = 1'b0,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic              sck,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              rw,
   input  logic [1:0]        addr,
   input  logic [31:0]       mosi,
   output logic [31:0]       miso,
   output logic [DIGITS-1:0] seg_sel,
   output logic [7:0]        seg_code
);

   localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW}};

   typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

   logic [31:0]       data_q, sh_data_q;
   logic              en_q, hex_q, lzs_q, sh_hex_q, sh_lzs_q;
   logic [DIGITS-1:0] dp_q, blank_q, sh_dp_q, sh_blank_q;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt, load_idx;
   logic [DIGITS-1:0] sel_q, sel_d, sel_act;
   logic [7:0]        code_q, code_d, code_act;
   logic              load, use_live, upper_zero;

   logic [31:0]       src_data;
   logic              src_hex, src_lzs;
   logic [DIGITS-1:0] src_dp, src_blank;
   logic [3:0]        nib;

   function automatic logic [6:0] seg7(input logic [3:0] n, input logic hex);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3f;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5b;
         4'h3: s = 7'h4f;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6d;
         4'h6: s = 7'h7d;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7f;
         4'h9: s = 7'h6f;
         4'ha: s = 7'h77;
         4'hb: s = 7'h7c;
         4'hc: s = 7'h39;
         4'hd: s = 7'h5e;
         4'he: s = 7'h79;
         default: s = 7'h71;
      endcase
      if (!hex && n > 4'd9) s = 7'h40;
      return s;
   endfunction

   always_ff @(posedge sck or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         en_q    <= 1'b1;
         hex_q   <= 1'b1;
         lzs_q   <= 1'b0;
         dp_q    <= '0;
         blank_q <= '0;
      end else if (!cs_n && rw) begin
         case (addr)
            2'd0: data_q <= mosi;
            2'd1: {lzs_q, hex_q, en_q} <= mosi[2:0];
            2'd2: dp_q <= mosi[DIGITS-1:0];
            default: blank_q <= mosi[DIGITS-1:0];
         endcase
      end
   end

   always_comb begin
      miso = '0;
      if (!cs_n && !rw) begin
         case (addr)
            2'd0: miso = data_q;
            2'd1: miso = {29'd0, lzs_q, hex_q, en_q};
            2'd2: miso = 32'(dp_q);
            default: miso = 32'(blank_q);
         endcase
      end
   end

   // Digit 0 is decoded from the live registers on the very edge they are copied
   // into the shadow, so the whole frame comes from one consistent snapshot.
   always_comb begin
      use_live  = (load_idx == '0);
      src_data  = use_live ? data_q  : sh_data_q;
      src_hex   = use_live ? hex_q   : sh_hex_q;
      src_lzs   = use_live ? lzs_q   : sh_lzs_q;
      src_dp    = use_live ? dp_q    : sh_dp_q;
      src_blank = use_live ? blank_q : sh_blank_q;
      nib = 4'(src_data >> {load_idx, 2'b00});
      upper_zero = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
         if (j >= int'(load_idx) && src_data[4*j +: 4] != 4'h0) upper_zero = 1'b0;
      end
      code_act = {src_dp[load_idx], seg7(nib, src_hex)};
      if (src_blank[load_idx] || (src_lzs && load_idx != '0 && upper_zero)) code_act = 8'h00;
      sel_act = DIGITS'(1) << load_idx;
   end

   assign idx_nxt = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      sel_d    = sel_q;
      code_d   = code_q;
      load     = 1'b0;
      load_idx = idx_q;
      if (!en_q) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
         sel_d   = SEL_OFF;
         code_d  = SEG_OFF;
      end else begin
         case (state_q)
            IDLE: begin
               idx_d = '0;
               if (GAP_CYCLES == 0) begin
                  load     = 1'b1;
                  load_idx = '0;
               end else begin
                  state_d = GAP;
                  cnt_d   = CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q >= CNT_W'(GAP_CYCLES)) load = 1'b1;
               else cnt_d = cnt_q + 1'b1;
            end
            default: begin
               if (cnt_q >= CNT_W'(SCAN_DIV)) begin
                  sel_d  = SEL_OFF;
                  code_d = SEG_OFF;
                  idx_d  = idx_nxt;
                  if (GAP_CYCLES == 0) begin
                     load     = 1'b1;
                     load_idx = idx_nxt;
                  end else begin
                     state_d = GAP;
                     cnt_d   = CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
         if (load) begin
            state_d = SHOW;
            cnt_d   = CNT_W'(1);
            idx_d   = load_idx;
            sel_d   = SEL_ACTIVE_LOW ? ~sel_act : sel_act;
            code_d  = SEG_ACTIVE_LOW ? ~code_act : code_act;
         end
      end
   end

   always_ff @(posedge sck or negedge rst) begin
      if (!rst) begin
         state_q <= GAP;
         cnt_q   <= '0;
         idx_q   <= '0;
         sel_q   <= SEL_OFF;
         code_q  <= SEG_OFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         code_q  <= code_d;
      end
   end

   always_ff @(posedge sck or negedge rst) begin
      if (!rst) begin
         sh_data_q  <= '0;
         sh_hex_q   <= 1'b1;
         sh_lzs_q   <= 1'b0;
         sh_dp_q    <= '0;
         sh_blank_q <= '0;
      end else if (load && use_live) begin
         sh_data_q  <= data_q;
         sh_hex_q   <= hex_q;
         sh_lzs_q   <= lzs_q;
         sh_dp_q    <= dp_q;
         sh_blank_q <= blank_q;
      end
   end

   assign seg_sel  = sel_q;
   assign seg_code = code_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: an 8-digit active-high instance walked frame by
// frame, plus a 4-digit active-low instance for polarity and async reset.
module tb_seg_scan_ctrl;

   logic        sck;
   logic        rst_n, cs_n, rw;
   logic [1:0]  addr;
   logic [31:0] mosi, miso;
   logic [7:0]  seg_sel, seg_code;

   logic        lo_rst_n, lo_cs_n, lo_rw;
   logic [1:0]  lo_addr;
   logic [31:0] lo_mosi, lo_miso;
   logic [3:0]  lo_sel;
   logic [7:0]  lo_code;

   int checks = 0;
   int fails  = 0;

   logic        wr_v [8];
   logic [1:0]  wr_a [8];
   logic [31:0] wr_d [8];

   seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4), .GAP_CYCLES(1),
                   .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_dut (
      .sck(sck), .rst(rst_n), .cs_n(cs_n), .rw(rw), .addr(addr), .mosi(mosi),
      .miso(miso), .seg_sel(seg_sel), .seg_code(seg_code));

   seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(3), .GAP_CYCLES(1),
                   .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_lo (
      .sck(sck), .rst(lo_rst_n), .cs_n(lo_cs_n), .rw(lo_rw), .addr(lo_addr), .mosi(lo_mosi),
      .miso(lo_miso), .seg_sel(lo_sel), .seg_code(lo_code));

   initial begin
      sck = 1'b0;
      forever #5 sck = ~sck;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sck);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      cs_n = 1'b0; rw = 1'b1; addr = a; mosi = d;
      tick();
      cs_n = 1'b1; rw = 1'b0; mosi = '0;
   endtask

   task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
      cs_n = 1'b0; rw = 1'b0; addr = a;
      #1;
      chk(tag, miso, exp);
      cs_n = 1'b1;
   endtask

   task automatic lo_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
      lo_cs_n = 1'b0; lo_rw = 1'b0; lo_addr = a;
      #1;
      chk(tag, lo_miso, exp);
      lo_cs_n = 1'b1;
   endtask

   // Entered just after the edge that lights digit 0; leaves just after the edge
   // that lights digit 0 of the following frame. Writes queued in wr_* replace
   // the first hold cycle of their digit.
   task automatic show_frame(input string tag, input logic [63:0] codes);
      for (int k = 0; k < 8; k++) begin
         logic [7:0] c;
         c = codes[63-8*k -: 8];
         chk($sformatf("%s d%0d sel", tag, k), 32'(seg_sel), 32'(8'd1 << k));
         chk($sformatf("%s d%0d code", tag, k), 32'(seg_code), 32'(c));
         if (wr_v[k]) bus_write(wr_a[k], wr_d[k]);
         else tick();
         tick();
         tick();
         chk($sformatf("%s d%0d hold", tag, k), {seg_sel, seg_code}, {8'd1 << k, c});
         tick();
         chk($sformatf("%s d%0d gap", tag, k), {seg_sel, seg_code}, 32'h0);
         tick();
      end
      for (int k = 0; k < 8; k++) wr_v[k] = 1'b0;
   endtask

   task automatic queue_wr(input int k, input logic [1:0] a, input logic [31:0] d);
      wr_v[k] = 1'b1; wr_a[k] = a; wr_d[k] = d;
   endtask

   initial begin
      for (int k = 0; k < 8; k++) begin
         wr_v[k] = 1'b0; wr_a[k] = '0; wr_d[k] = '0;
      end
      rst_n = 1'b1; cs_n = 1'b1; rw = 1'b0; addr = '0; mosi = '0;
      lo_rst_n = 1'b1; lo_cs_n = 1'b1; lo_rw = 1'b0; lo_addr = '0; lo_mosi = '0;
      #2;
      rst_n = 1'b0;
      lo_rst_n = 1'b0;
      tick();
      tick();
      chk("rst sel", 32'(seg_sel), 32'h00);
      chk("rst code", 32'(seg_code), 32'h00);
      chk("rst miso idle", miso, 32'h0);
      chk("lo rst sel", 32'(lo_sel), 32'hf);
      chk("lo rst code", 32'(lo_code), 32'hff);
      rst_n = 1'b1;
      bus_read("rst ctrl", 2'd1, 32'h3);
      bus_read("rst data", 2'd0, 32'h0);

      bus_write(2'd0, 32'h12345678);
      chk("gap after write", {seg_sel, seg_code}, 32'h0);
      tick();
      queue_wr(3, 2'd0, 32'hFEDCBA98);
      show_frame("f1 dec", 64'h7f077d6d664f5b06);
      queue_wr(2, 2'd1, 32'h1);
      show_frame("f2 hex", 64'h7f6f777c395e7971);
      queue_wr(1, 2'd1, 32'h5);
      queue_wr(2, 2'd0, 32'h0);
      show_frame("f3 nohex", 64'h7f6f404040404040);
      queue_wr(1, 2'd0, 32'h00010200);
      show_frame("f4 lzs0", 64'h3f00000000000000);
      queue_wr(1, 2'd1, 32'h3);
      queue_wr(2, 2'd2, 32'h05);
      queue_wr(3, 2'd3, 32'h02);
      queue_wr(4, 2'd0, 32'h0);
      show_frame("f5 lzs", 64'h3f3f5b3f06000000);
      show_frame("f6 dpblank", 64'hbf00bf3f3f3f3f3f);

      bus_read("rd dp", 2'd2, 32'h05);
      bus_read("rd blank", 2'd3, 32'h02);
      bus_read("rd ctrl", 2'd1, 32'h3);
      addr = 2'd2;
      #1;
      chk("rd cs_n high", miso, 32'h0);

      chk("en lit", {seg_sel, seg_code}, {8'h01, 8'hbf});
      bus_write(2'd1, 32'h2);
      chk("en wr edge lit", {seg_sel, seg_code}, {8'h01, 8'hbf});
      bus_read("en ctrl rb", 2'd1, 32'h2);
      tick();
      chk("en off", {seg_sel, seg_code}, 32'h0);
      tick();
      chk("en off hold", {seg_sel, seg_code}, 32'h0);
      bus_write(2'd1, 32'h3);
      chk("reen edge0", {seg_sel, seg_code}, 32'h0);
      tick();
      chk("reen edge1", {seg_sel, seg_code}, 32'h0);
      tick();
      chk("reen edge2", {seg_sel, seg_code}, {8'h01, 8'hbf});
      show_frame("f7 reen", 64'hbf00bf3f3f3f3f3f);

      lo_rst_n = 1'b1;
      lo_cs_n = 1'b0; lo_rw = 1'b1; lo_addr = 2'd0; lo_mosi = 32'h1;
      tick();
      lo_cs_n = 1'b1; lo_rw = 1'b0; lo_mosi = '0;
      chk("lo gap", {lo_sel, lo_code}, 12'hfff);
      tick();
      chk("lo d0 sel", 32'(lo_sel), 32'he);
      chk("lo d0 code", 32'(lo_code), 32'hf9);
      tick();
      chk("lo d0 hold", {lo_sel, lo_code}, {4'he, 8'hf9});
      lo_rst_n = 1'b0;
      #1;
      chk("lo async sel", 32'(lo_sel), 32'hf);
      chk("lo async code", 32'(lo_code), 32'hff);
      lo_read("lo rst data", 2'd0, 32'h0);
      lo_read("lo rst ctrl", 2'd1, 32'h3);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
